// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scan-code constants, frame FSM encoding and parity helper
package ps2_pkg;

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_ones(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - PS/2 pin synchronizers, ps2_clk stability filter and fall detect
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_fall,
  output logic o_data_s
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          r_clk_meta;
  logic          r_clk_sync;
  logic          r_dat_meta;
  logic          r_dat_sync;
  logic          r_filt;
  logic [CW-1:0] r_cnt;
  logic          r_fall;

  // Idle bus level is high, so every stage resets to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_filt     <= 1'b1;
      r_cnt      <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_meta <= i_ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= i_ps2_data;
      r_dat_sync <= r_dat_meta;
      r_fall     <= 1'b0;
      if (r_clk_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_cnt  <= '0;
        r_filt <= r_clk_sync;
        r_fall <= r_filt;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_fall   = r_fall;
  assign o_data_s = r_dat_sync;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver with make/break/extended decode and space-key start pulse
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_code,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       is_break,
  output logic       is_extended,
  output logic       space_press,
  output logic       space_held
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          w_fall;
  logic          w_data_s;
  logic          w_frame_ok;
  logic          w_timeout;

  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          r_brk_flag;
  logic          r_ext_flag;
  logic [7:0]    r_code;
  logic          r_valid;
  logic          r_err;
  logic          r_is_break;
  logic          r_is_ext;
  logic          r_press;
  logic          r_held;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
    .clk       (clk),
    .reset     (reset),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_fall    (w_fall),
    .o_data_s  (w_data_s)
  );

  assign w_frame_ok = w_data_s & odd_ones({r_shift, r_parity});
  assign w_timeout  = (r_state != ST_IDLE) && !w_fall &&
                      (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_to_cnt   <= '0;
      r_brk_flag <= 1'b0;
      r_ext_flag <= 1'b0;
      r_code     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_is_break <= 1'b0;
      r_is_ext   <= 1'b0;
      r_press    <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_press <= 1'b0;
      r_to_cnt <= (r_state == ST_IDLE || w_fall) ? '0 : r_to_cnt + 1'b1;

      if (w_timeout) begin
        r_state    <= ST_IDLE;
        r_err      <= 1'b1;
        r_brk_flag <= 1'b0;
        r_ext_flag <= 1'b0;
      end else if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_data_s) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            r_shift   <= {w_data_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_parity <= w_data_s;
            r_state  <= ST_STOP;
          end
          default: begin
            r_state <= ST_IDLE;
            if (!w_frame_ok) begin
              r_err      <= 1'b1;
              r_brk_flag <= 1'b0;
              r_ext_flag <= 1'b0;
            end else if (r_shift == SC_BREAK) begin
              r_brk_flag <= 1'b1;
            end else if (r_shift == SC_EXT) begin
              r_ext_flag <= 1'b1;
            end else begin
              r_code     <= r_shift;
              r_valid    <= 1'b1;
              r_is_break <= r_brk_flag;
              r_is_ext   <= r_ext_flag;
              r_brk_flag <= 1'b0;
              r_ext_flag <= 1'b0;
              // Only the plain (non-E0) space key drives the start outputs.
              if (r_shift == SC_SPACE && !r_ext_flag) begin
                if (r_brk_flag) begin
                  r_held <= 1'b0;
                end else if (!r_held) begin
                  r_press <= 1'b1;
                  r_held  <= 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign rx_code     = r_code;
  assign rx_valid    = r_valid;
  assign rx_err      = r_err;
  assign is_break    = r_is_break;
  assign is_extended = r_is_ext;
  assign space_press = r_press;
  assign space_held  = r_held;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - randomized self-checking bench for ps2_keyboard_rx against a scan-code model
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;
  localparam int HALF       = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_code;
  logic       rx_valid;
  logic       rx_err;
  logic       is_break;
  logic       is_extended;
  logic       space_press;
  logic       space_held;

  int total = 0;
  int bad   = 0;

  int n_valid = 0;
  int n_err   = 0;
  int n_press = 0;

  logic [7:0] m_code;
  logic       m_isb, m_ise, m_held, m_brk, m_ext;
  int         e_valid, e_err, e_press;

  ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_code    (rx_code),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .is_break   (is_break),
    .is_extended(is_extended),
    .space_press(space_press),
    .space_held (space_held)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) n_valid++;
    if (rx_err === 1'b1) n_err++;
    if (space_press === 1'b1) n_press++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_code = 8'h00; m_isb = 0; m_ise = 0; m_held = 0; m_brk = 0; m_ext = 0;
  endtask

  // Expected effect of one whole frame, from the scan-code protocol rules.
  task automatic model_frame(input logic [7:0] b, input bit pbad, input bit sbad);
    e_valid = 0; e_err = 0; e_press = 0;
    if (pbad || sbad) begin
      e_err = 1; m_brk = 0; m_ext = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      e_valid = 1;
      m_code = b; m_isb = m_brk; m_ise = m_ext;
      if (b == 8'h29 && !m_ext) begin
        if (m_brk) m_held = 0;
        else if (!m_held) begin e_press = 1; m_held = 1; end
      end
      m_brk = 0; m_ext = 0;
    end
  endtask

  task automatic clear_counts();
    @(posedge clk);
    n_valid = 0; n_err = 0; n_press = 0;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pbad, input bit sbad);
    logic [10:0] f;
    f = {~sbad, ~(^b) ^ pbad, b, 1'b0};
    send_bits(f, 11);
    ps2_data = 1'b1;
    repeat (3 * HALF) @(posedge clk);
  endtask

  task automatic frame_check(input string tag, input logic [7:0] b, input bit pbad, input bit sbad);
    clear_counts();
    model_frame(b, pbad, sbad);
    send_frame(b, pbad, sbad);
    @(negedge clk);
    check({tag, ".valid"}, n_valid, e_valid);
    check({tag, ".err"},   n_err,   e_err);
    check({tag, ".press"}, n_press, e_press);
    check({tag, ".code"},  rx_code, m_code);
    check({tag, ".brk"},   is_break, m_isb);
    check({tag, ".ext"},   is_extended, m_ise);
    check({tag, ".held"},  space_held, m_held);
  endtask

  initial begin
    logic [7:0] b;
    logic [10:0] f;
    bit pb, sb;

    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset.outs", {rx_code, rx_valid, rx_err, is_break, is_extended, space_press, space_held}, 0);
    reset = 1'b1;
    repeat (10) @(posedge clk);

    frame_check("space_make", 8'h29, 0, 0);
    frame_check("rep1", 8'h29, 0, 0);
    frame_check("rep2", 8'h29, 0, 0);
    frame_check("rep3", 8'h29, 0, 0);
    frame_check("brk_pfx", 8'hF0, 0, 0);
    frame_check("space_brk", 8'h29, 0, 0);
    frame_check("make_again", 8'h29, 0, 0);
    frame_check("par_err", 8'h29, 1, 0);
    frame_check("ext_pfx", 8'hE0, 0, 0);
    frame_check("ext_29", 8'h29, 0, 0);
    frame_check("stop_err", 8'h1C, 0, 1);

    // Partial frame then silence: exactly one timeout error.
    clear_counts();
    f = {1'b1, 1'b0, 8'h1C, 1'b0};
    send_bits(f, 5);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 200) @(posedge clk);
    @(negedge clk);
    check("timeout.err", n_err, 1);
    check("timeout.valid", n_valid, 0);
    m_brk = 0; m_ext = 0;
    frame_check("after_to", 8'h1C, 0, 0);

    clear_counts();
    for (int g = 0; g < 4; g++) begin
      ps2_data = 1'b0;
      ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (HALF) @(posedge clk);
    end
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    @(negedge clk);
    check("glitch.events", n_valid + n_err, 0);
    frame_check("post_glitch", 8'h29, 0, 0);

    // Reset in the middle of the data bits.
    f = {1'b1, 1'b0, 8'h29, 1'b0};
    send_bits(f, 4);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mid.outs", {rx_code, rx_valid, rx_err, is_break, is_extended, space_press, space_held}, 0);
    model_reset();
    ps2_data = 1'b1;
    reset = 1'b1;
    repeat (50) @(posedge clk);
    frame_check("post_rst", 8'h29, 0, 0);

    for (int k = 0; k < 50; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: b = 8'h29;
        3:       b = 8'hF0;
        4:       b = 8'hE0;
        default: b = 8'($urandom);
      endcase
      pb = ($urandom_range(0, 9) == 0);
      sb = ($urandom_range(0, 14) == 0);
      frame_check($sformatf("rnd%0d", k), b, pb, sb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Input-side counterpart to the VGA text screens: receives PS/2 keyboard frames, decodes make/break/extended prefixes and reports scan codes.
- Generates the single-cycle start pulse that the "PRESS SPACE TO START" screen asks for.
- Sits between the board PS/2 pins and the game FSM; shares the system clock with vga_sync.

Parameters:
- FILTER_LEN, 8: consecutive clk cycles the synchronized ps2_clk must hold a new level before the filtered clock changes.
- TIMEOUT_CYCLES, 100000: clk cycles with no filtered falling edge inside a frame before the frame is aborted (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0); one clock domain only
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- rx_code  out  8  last correctly received byte, held until the next valid byte
- rx_valid  out  1  one-cycle pulse when rx_code updates
- rx_err  out  1  one-cycle pulse on parity error, stop-bit error or timeout
- is_break  out  1  qualifies rx_valid: byte was preceded by F0
- is_extended  out  1  qualifies rx_valid: byte was preceded by E0
- space_press  out  1  one-cycle pulse on the first make of the space key (0x29, not extended)
- space_held  out  1  level; 1 between space make and space break

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, prefix flags cleared, filtered clock 1.
- Input conditioning
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - Filtered clock is derived from the synchronized clock by the FILTER_LEN stability counter.
  - A fall is the cycle the filtered clock goes 1->0; the synchronized data bit is sampled on that cycle.
- Frame FSM: IDLE, DATA, PARITY, STOP.
  - IDLE: on a fall with data=0 (start bit), go to DATA and clear the bit count. On a fall with data=1, stay in IDLE (no error).
  - DATA: shift in 8 bits, LSB first. After the 8th bit go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: the frame is accepted only if data=1 and total ones in data+parity is odd. Otherwise pulse rx_err. Return to IDLE either way.
  - Timeout: in any non-IDLE state, the counter resets on each fall. Reaching TIMEOUT_CYCLES pulses rx_err and forces IDLE; the partial byte is discarded.
- Decode on an accepted byte
  - F0: set the break flag. E0: set the extended flag. Neither updates rx_code nor pulses rx_valid.
  - Any other byte: rx_code <= byte and rx_valid=1 for one cycle, on the clock after the stop-bit fall.
  - At the same time is_break/is_extended take the current flag values; flags clear in the same cycle.
  - is_break/is_extended hold until the next rx_valid.
  - On rx_err, prefix flags are cleared.
- Space key
  - On rx_valid with code 0x29, non-extended, non-break and space_held=0: space_press=1 in the same cycle as rx_valid, and space_held <= 1.
  - Typematic repeats of 0x29 while held produce no pulse.
  - Break of 0x29 clears space_held.
  - E0 29 is ignored for both space outputs.
- Reset mid-frame: immediate return to reset values; the next complete frame decodes normally.

Decomposition:
- ps2_pkg: SC_SPACE=8'h29, SC_BREAK=8'hF0, SC_EXT=8'hE0, FSM state encoding.
- Sub-module ps2_sync_filter: synchronizer, stability filter and fall-edge detect for ps2_clk; also carries the data synchronizer. Outputs fall and data_s.

Test Plan:
- Frame 0x29 (bits 1,0,0,1,0,1,0,0, parity 0, stop 1) -> rx_valid one cycle, rx_code=0x29, is_break=0, space_press=1, space_held=1.
- Frames 29,29,29, then F0,29 -> exactly one space_press. Third 29 leaves space_held=1. After F0,29: rx_valid with is_break=1, rx_code=0x29, space_held=0.
- Frame 0x29 with parity 1 -> rx_err pulse. No rx_valid, no space_press, rx_code unchanged.
- E0 (parity 0), then 29 -> rx_valid with is_extended=1. No space_press, space_held unchanged.
- Five bits of a frame, then idle for TIMEOUT_CYCLES -> rx_err once, FSM in IDLE. Following frame 0x1C (parity 0) -> rx_code=0x1C.
- 2-cycle glitches on ps2_clk in IDLE -> no state change. Reset asserted during DATA -> all outputs 0; next 0x29 frame decodes correctly.
